// File: rtl/paddle_emulator.sv
// Digital replacement for the 555 paddle: answers each game trigger with a pulse
// whose width is (BASE_UNITS+pos)*TICK_DIV clocks. Define PADDLE_QUAD_EN for encoder input.
module paddle_emulator #(
  parameter int TICK_DIV   = 909,
  parameter int BASE_UNITS = 16,
  parameter int POS_MAX    = 215,
  parameter int POS_INIT   = 107,
  parameter int STEP       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_trg_n,
  input  logic       btn_up,
  input  logic       btn_dn,
`ifdef PADDLE_QUAD_EN
  input  logic       quad_a,
  input  logic       quad_b,
`endif
  output logic       pad_out,
  output logic       busy,
  output logic [7:0] pos
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_PULSE = 1'b1;

  logic [0:0]        state;
  logic [TICK_W-1:0] tick;
  logic [7:0]        units;
  logic [7:0]        pos_nxt;

  logic       trg_s1, trg_s2, trg_s3;
  logic [2:0] vld;
  logic       armed;
  logic       trig;
  logic       trig_accept;

  // vld tracks how far real samples have travelled down the synchronizers after reset;
  // armed demands one genuine high sample so a trigger held through reset is not taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trg_s1 <= 1'b1;
      trg_s2 <= 1'b1;
      trg_s3 <= 1'b1;
      vld    <= 3'b000;
      armed  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the chain shift by one stage per clock.
      trg_s1 <= pad_trg_n;
      trg_s2 <= trg_s1;
      trg_s3 <= trg_s2;
      vld    <= {vld[1:0], 1'b1};
      if (vld[1] && trg_s2) armed <= 1'b1;
    end
  end

  assign trig        = armed & trg_s3 & ~trg_s2;
  assign trig_accept = trig && (state == ST_IDLE);

`ifdef PADDLE_QUAD_EN
  logic       qa_s1, qa_s2, qb_s1, qb_s2;
  logic [1:0] q_prev;
  logic       q_up, q_dn;
  logic       unused_btn;

  assign unused_btn = btn_up ^ btn_dn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qa_s1  <= 1'b0;
      qa_s2  <= 1'b0;
      qb_s1  <= 1'b0;
      qb_s2  <= 1'b0;
      q_prev <= 2'b00;
    end else begin
      qa_s1  <= quad_a;
      qa_s2  <= qa_s1;
      qb_s1  <= quad_b;
      qb_s2  <= qb_s1;
      q_prev <= {qa_s2, qb_s2};
    end
  end

  // Forward Gray order is 00->01->11->10->00; double-bit changes fall to default.
  always_comb begin
    q_up = 1'b0;
    q_dn = 1'b0;
    if (vld[2]) begin
      case ({q_prev, qa_s2, qb_s2})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: q_up = 1'b1;
        4'b0010, 4'b1011, 4'b1101, 4'b0100: q_dn = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: assigning a default first keeps this block purely combinational (no latch).
    pos_nxt = pos;
    if (q_up && pos != 8'(POS_MAX))
      pos_nxt = pos + 8'd1;
    else if (q_dn && pos != 8'd0)
      pos_nxt = pos - 8'd1;
  end
`else
  logic [8:0] pos_wide;

  // The 9-bit intermediate exposes underflow in bit 8 and overflow above POS_MAX.
  always_comb begin
    pos_nxt  = pos;
    pos_wide = {1'b0, pos};
    if (trig_accept) begin
      if (btn_up && !btn_dn) begin
        pos_wide = {1'b0, pos} - 9'(STEP);
        pos_nxt  = pos_wide[8] ? 8'd0 : pos_wide[7:0];
      end else if (btn_dn && !btn_up) begin
        pos_wide = {1'b0, pos} + 9'(STEP);
        pos_nxt  = (pos_wide > 9'(POS_MAX)) ? 8'(POS_MAX) : pos_wide[7:0];
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pos <= 8'(POS_INIT);
    else       pos <= pos_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      tick    <= '0;
      units   <= 8'd0;
      pad_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig_accept) begin
            units   <= 8'(BASE_UNITS) + pos;
            tick    <= TICK_RELOAD;
            pad_out <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (tick == '0) begin
            if (units == 8'd1) begin
              pad_out <= 1'b0;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              units <= units - 8'd1;
              tick  <= TICK_RELOAD;
            end
          end else begin
            tick <= tick - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_emulator.sv
// Scoreboard bench for paddle_emulator with a shortened TICK_DIV; expected pulse
// widths are queued at trigger time and compared when each pulse ends.
module tb_paddle_emulator;

  localparam int T        = 3;
  localparam int BASE     = 16;
  localparam int PMAX     = 215;
  localparam int PINIT    = 107;
  localparam int STEP     = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pad_trg_n = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
`ifdef PADDLE_QUAD_EN
  logic       quad_a = 1'b0;
  logic       quad_b = 1'b0;
`endif
  logic       pad_out;
  logic       busy;
  logic [7:0] pos;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_pos   = PINIT;
  int exp_q[$];

  paddle_emulator #(
    .TICK_DIV(T), .BASE_UNITS(BASE), .POS_MAX(PMAX), .POS_INIT(PINIT), .STEP(STEP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pad_trg_n(pad_trg_n),
    .btn_up(btn_up),
    .btn_dn(btn_dn),
`ifdef PADDLE_QUAD_EN
    .quad_a(quad_a),
    .quad_b(quad_b),
`endif
    .pad_out(pad_out),
    .busy(busy),
    .pos(pos)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int next_pos(input int p, input bit up, input bit dn);
`ifdef PADDLE_QUAD_EN
    return p;
`else
    if (up && !dn) return (p - STEP < 0) ? 0 : p - STEP;
    if (dn && !up) return (p + STEP > PMAX) ? PMAX : p + STEP;
    return p;
`endif
  endfunction

  // Pulse monitor: measures each pad_out high period and pops the expected width.
  initial begin
    bit prev;
    int start;
    prev  = 1'b0;
    start = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (pad_out && !prev) start = cyc;
        if (!pad_out && prev) begin
          if (exp_q.size() == 0) check("unexpected_pulse", cyc - start, -1);
          else                   check("pulse_width", cyc - start, exp_q.pop_front());
        end
        prev = pad_out;
      end
    end
  end

  task automatic fire(input int low_cycles);
    @(posedge clk); #1 pad_trg_n = 1'b0;
    repeat (low_cycles) @(posedge clk);
    #1 pad_trg_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic issue();
    exp_q.push_back((BASE + m_pos) * T);
    m_pos = next_pos(m_pos, btn_up, btn_dn);
    fire(2);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check({tag, "_timeout"}, 1, 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

`ifdef PADDLE_QUAD_EN
  task automatic qstep(input bit a, input bit b, input bit valid);
    quad_a = a;
    quad_b = b;
    if (valid && m_pos < PMAX) m_pos++;
    repeat (4) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    int highs;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pad_out", pad_out, 0);
    check("rst_busy", busy, 0);
    check("rst_pos", pos, PINIT);
    reset = 1'b0;
    repeat (6) @(posedge clk);

    // Trigger latency and nominal pulse
    @(posedge clk); #1 pad_trg_n = 1'b0;
    exp_q.push_back((BASE + m_pos) * T);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("rise_edge%0d", k), pad_out, (k == 3) ? 1 : 0);
    end
    check("busy_in_pulse", busy, 1);
    repeat (7) @(posedge clk);
    #1 pad_trg_n = 1'b1;
    wait_idle("nominal");
    check("pos_nominal", pos, m_pos);

    // Up button: walk to zero and saturate
    btn_up = 1'b1;
    for (int i = 0; i < 56; i++) begin
      issue();
      wait_idle("up");
      check("pos_up", pos, m_pos);
    end
    btn_up = 1'b0;
`ifndef PADDLE_QUAD_EN
    check("pos_floor", pos, 0);
`endif

    // Down button: walk to POS_MAX and saturate
    btn_dn = 1'b1;
    for (int i = 0; i < 110; i++) begin
      issue();
      wait_idle("dn");
      check("pos_dn", pos, m_pos);
    end
    btn_dn = 1'b0;
`ifndef PADDLE_QUAD_EN
    check("pos_ceiling", pos, PMAX);
`endif

    // Retrigger during a pulse is ignored
    btn_up = 1'b1;
    issue();
    repeat (15) @(posedge clk);
    #1 pad_trg_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 pad_trg_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("busy_after_retrig", busy, 1);
    check("pos_stable_in_pulse", pos, m_pos);
    wait_idle("retrig");
    check("pos_retrig", pos, m_pos);
    btn_up = 1'b0;

    // Reset mid-pulse, trigger held low through release
    fire(2);
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    pad_trg_n = 1'b0;
    #1;
    check("midrst_pad_out", pad_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pos", pos, PINIT);
    m_pos = PINIT;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    highs = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (pad_out || busy) highs++;
    end
    check("held_low_no_pulse", highs, 0);
    pad_trg_n = 1'b1;
    repeat (6) @(posedge clk);
    issue();
    wait_idle("post_reset");
    check("pos_post_reset", pos, m_pos);

`ifdef PADDLE_QUAD_EN
    // Quadrature: two full forward cycles, then an invalid jump
    for (int r = 0; r < 2; r++) begin
      qstep(1'b0, 1'b1, 1'b1);
      qstep(1'b1, 1'b1, 1'b1);
      qstep(1'b1, 1'b0, 1'b1);
      qstep(1'b0, 1'b0, 1'b1);
    end
    check("quad_fwd8", pos, m_pos);
    qstep(1'b1, 1'b1, 1'b0);
    check("quad_invalid", pos, m_pos);
    // Steps during a pulse change pos but not the pulse already in flight
    issue();
    for (int r = 0; r < 2; r++) begin
      qstep(1'b1, 1'b0, 1'b1);
      qstep(1'b0, 1'b0, 1'b1);
      qstep(1'b0, 1'b1, 1'b1);
      qstep(1'b1, 1'b1, 1'b1);
    end
    check("quad_in_pulse_busy", busy, 1);
    wait_idle("quad");
    check("quad_pos_after", pos, m_pos);
`endif

    repeat (10) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
